// File: rtl/clock_display_scan.sv
// Four-digit common-anode seven-segment scanner for the clock: shows HH:MM or
// MM:SS, lights the colon on slot 2, blinks the field under edit.
module clock_display_scan #(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned LZ_BLANK    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       view_sel,
  input  logic       edit_en,
  input  logic       edit_pos,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0]  SEG_OFF  = 7'b1111111;
  localparam logic [6:0]  SEG_DASH = 7'b0111111;

  logic [REF_W-1:0] ref_cnt;
  logic [BLK_W-1:0] blk_cnt;
  logic [1:0]       idx;
  logic             phase;

  logic [3:0] digit;
  logic       field_sel;
  logic       blank;
  logic       lz_hide;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [3:0] an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_DASH;
    endcase
  endfunction

  // Slot scan and blink phase both free-run regardless of inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
      blk_cnt <= '0;
      phase   <= 1'b1;
    end else begin
      if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + REF_W'(1);
      end
      if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

  always_comb begin
    digit     = 4'd0;
    field_sel = 1'b0;
    case ({view_sel, idx})
      3'b0_11: digit = h2;
      3'b0_10: digit = h1;
      3'b0_01: digit = m2;
      3'b0_00: digit = m1;
      3'b1_11: digit = m2;
      3'b1_10: digit = m1;
      3'b1_01: digit = s2;
      default: digit = s1;
    endcase
    // idx[1] marks the left pair; MM:SS has no hours field to blink
    if (view_sel) field_sel = ~edit_pos & idx[1];
    else          field_sel = edit_pos ? idx[1] : ~idx[1];
    blank   = edit_en & ~phase & field_sel;
    lz_hide = (LZ_BLANK != 0) && !view_sel && (idx == 2'd3) && (h2 == 4'd0);

    seg_nxt = lz_hide ? SEG_OFF : decode(digit);
    dp_nxt  = (idx != 2'd2);
    an_nxt  = ~(4'b0001 << idx);
    if (blank) begin
      seg_nxt = SEG_OFF;
      dp_nxt  = 1'b1;
      an_nxt  = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_OFF;
      dp  <= 1'b1;
      an  <= 4'b1111;
    end else begin
      seg <= seg_nxt;
      dp  <= dp_nxt;
      an  <= an_nxt;
    end
  end

endmodule
